// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, branch squash,
// data-memory wait/timeout FSM and saturating stall/flush counters.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             PC_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ctrl_hazard,
    output logic             pipe_freeze,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic luh, mw;
    logic run_pc, run_ifw, run_flush, run_hz;
    logic pc_c, ifw_c, flush_c, hz_c, frz_c, err_c;

    always_comb begin
        luh = idex_mem_read && (idex_rd != 5'd0) &&
              ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
        mw  = mem_req && !mem_ack;

        // Branch squash wins over load-use: the dependent instruction is discarded anyway.
        run_pc    = 1'b1;
        run_ifw   = 1'b1;
        run_flush = 1'b0;
        run_hz    = 1'b0;
        if (ex_branch_taken) begin
            run_flush = 1'b1;
            run_hz    = 1'b1;
        end else if (luh) begin
            run_pc  = 1'b0;
            run_ifw = 1'b0;
            run_hz  = 1'b1;
        end

        pc_c       = run_pc;
        ifw_c      = run_ifw;
        flush_c    = run_flush;
        hz_c       = run_hz;
        frz_c      = 1'b0;
        err_c      = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_RUN: begin
                if (mw) begin
                    pc_c       = 1'b0;
                    ifw_c      = 1'b0;
                    flush_c    = 1'b0;
                    hz_c       = 1'b0;
                    frz_c      = 1'b1;
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            S_MEM_WAIT: begin
                // An ack or an aborted request both release the freeze this cycle.
                if (mem_ack || !mem_req) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else begin
                    pc_c    = 1'b0;
                    ifw_c   = 1'b0;
                    flush_c = 1'b0;
                    hz_c    = 1'b0;
                    frz_c   = 1'b1;
                    if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
                        state_d = S_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                    end
                end
            end
            default: begin
                pc_c    = 1'b0;
                ifw_c   = 1'b0;
                flush_c = 1'b0;
                hz_c    = 1'b0;
                frz_c   = 1'b1;
                err_c   = 1'b1;
            end
        endcase

        stall_d = stall_q;
        if (!pc_c && (state_q != S_ERROR) && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        flush_d = flush_q;
        if (flush_c && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    // Reset forces every control output low, including PC_write/ifid_write.
    assign PC_write        = pc_c && !rst;
    assign ifid_write      = ifw_c && !rst;
    assign ifid_flush      = flush_c && !rst;
    assign ctrl_hazard     = hz_c && !rst;
    assign pipe_freeze     = frz_c && !rst;
    assign mem_timeout_err = err_c && !rst;
    assign stall_cycles    = stall_q;
    assign flush_count     = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b1;
    logic       rst;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       idex_mem_read, ex_branch_taken, mem_req, mem_ack;
    logic       PC_write, ifid_write, ifid_flush, ctrl_hazard, pipe_freeze, mem_timeout_err;
    logic [2:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
        .idex_mem_read(idex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .PC_write(PC_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .ctrl_hazard(ctrl_hazard), .pipe_freeze(pipe_freeze),
        .mem_timeout_err(mem_timeout_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct {
        string      nm;
        logic [5:0] f;   // {PC_write, ifid_write, ifid_flush, ctrl_hazard, pipe_freeze, mem_timeout_err}
        logic [2:0] st;
        logic [2:0] fl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] act_f;
            e     = exp_q.pop_front();
            act_f = {PC_write, ifid_write, ifid_flush, ctrl_hazard, pipe_freeze, mem_timeout_err};
            n_cmp++;
            if (act_f !== e.f || stall_cycles !== e.st || flush_count !== e.fl) begin
                n_bad++;
                $display("FAIL %s: got flags=%b stall=%0d flush=%0d, want flags=%b stall=%0d flush=%0d",
                         e.nm, act_f, stall_cycles, flush_count, e.f, e.st, e.fl);
            end else begin
                $display("ok   %s: flags=%b stall=%0d flush=%0d", e.nm, act_f, stall_cycles, flush_count);
            end
        end
    end

    task automatic push(input string nm, input logic [5:0] f, input int st, input int fl);
        exp_t e;
        e.nm = nm;
        e.f  = f;
        e.st = 3'(st);
        e.fl = 3'(fl);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic req, input logic ack,
                       input logic [5:0] f, input int st, input int fl);
        ifid_rs1        = rs1;
        ifid_rs2        = rs2;
        idex_rd         = rd;
        idex_mem_read   = mr;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ack         = ack;
        push(nm, f, st, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst             = 1'b1;
        ifid_rs1        = '0;
        ifid_rs2        = '0;
        idex_rd         = '0;
        idex_mem_read   = 1'b0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ack         = 1'b0;
        push(nm, 6'b000000, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [5:0] F_RUN   = 6'b110000;
    localparam logic [5:0] F_LUH   = 6'b000100;
    localparam logic [5:0] F_BR    = 6'b111100;
    localparam logic [5:0] F_FRZ   = 6'b000010;
    localparam logic [5:0] F_ERR   = 6'b000011;

    initial begin
        do_reset("reset0");

        // T1: load-use on rs2
        cyc("T1_luh",    5'd0, 5'd5, 5'd5, 1, 0, 0, 0, F_LUH, 0, 0);
        cyc("T1_after",  5'd0, 5'd5, 5'd9, 0, 0, 0, 0, F_RUN, 1, 0);
        cyc("T1_idle",   5'd1, 5'd2, 5'd3, 0, 0, 0, 0, F_RUN, 1, 0);
        // T2: load to x0 never stalls
        cyc("T2_rd_x0",  5'd0, 5'd0, 5'd0, 1, 0, 0, 0, F_RUN, 1, 0);
        cyc("T2_rs1",    5'd7, 5'd1, 5'd7, 1, 0, 0, 0, F_LUH, 1, 0);
        cyc("T2_nomr",   5'd7, 5'd1, 5'd7, 0, 0, 0, 0, F_RUN, 2, 0);

        // T3: branch overrides load-use
        do_reset("reset_T3");
        cyc("T3_br_luh", 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, F_BR,  0, 0);
        cyc("T3_after",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, F_RUN, 0, 1);

        // T4: memory wait with ack on the 4th cycle
        do_reset("reset_T4");
        cyc("T4_req",    5'd0, 5'd0, 5'd0, 0, 0, 1, 0, F_FRZ, 0, 0);
        cyc("T4_wait1",  5'd0, 5'd0, 5'd0, 0, 0, 1, 0, F_FRZ, 1, 0);
        cyc("T4_wait2",  5'd0, 5'd0, 5'd0, 0, 0, 1, 0, F_FRZ, 2, 0);
        cyc("T4_ack",    5'd0, 5'd0, 5'd0, 0, 0, 1, 1, F_RUN, 3, 0);
        cyc("T4_run",    5'd0, 5'd0, 5'd0, 0, 0, 0, 0, F_RUN, 3, 0);
        cyc("T4_zwait",  5'd0, 5'd0, 5'd0, 0, 0, 1, 1, F_RUN, 3, 0);
        // branch held during freeze takes effect only on the ack cycle
        cyc("T4b_req",   5'd0, 5'd0, 5'd0, 0, 1, 1, 0, F_FRZ, 3, 0);
        cyc("T4b_wait",  5'd0, 5'd0, 5'd0, 0, 1, 1, 0, F_FRZ, 4, 0);
        cyc("T4b_ack",   5'd0, 5'd0, 5'd0, 0, 1, 1, 1, F_BR,  5, 0);
        cyc("T4b_after", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, F_RUN, 5, 1);
        // aborted request releases the freeze
        cyc("T4c_req",   5'd0, 5'd0, 5'd0, 0, 0, 1, 0, F_FRZ, 5, 1);
        cyc("T4c_abort", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, F_RUN, 6, 1);
        cyc("T4c_idle",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, F_RUN, 6, 1);

        // T5: timeout with MEM_TIMEOUT=4
        do_reset("reset_T5");
        cyc("T5_req",    5'd0, 5'd0, 5'd0, 0, 0, 1, 0, F_FRZ, 0, 0);
        for (int i = 1; i <= 4; i++)
            cyc("T5_wait", 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, F_FRZ, i, 0);
        cyc("T5_err",    5'd0, 5'd0, 5'd0, 0, 0, 1, 0, F_ERR, 5, 0);
        cyc("T5_sticky", 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, F_ERR, 5, 0);
        do_reset("T5_rst");
        cyc("T5_post",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, F_RUN, 0, 0);

        // T6: stall counter saturates at 7
        do_reset("reset_T6");
        for (int i = 0; i < 10; i++)
            cyc("T6_stall", 5'd5, 5'd0, 5'd5, 1, 0, 0, 0, F_LUH, (i > 7) ? 7 : i, 0);
        cyc("T6_hold",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, F_RUN, 7, 0);
        // flush counter saturates as well
        do_reset("reset_T6b");
        for (int i = 0; i < 9; i++)
            cyc("T6_flush", 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, F_BR, 0, (i > 7) ? 7 : i);
        cyc("T6_fhold",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, F_RUN, 0, 7);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
